// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter slice.
// Contents:
//   DEF_DATA_W / DEF_ADDR_W : default value and register-index widths
//   REG_PC                  : register index that must never be written back
//   wb_entry_t              : one buffered writeback {dest, value}
package wb_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0] value;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of every bus-level signal around the writeback arbiter.
//   a_* / b_*    : producer request channels (valid/ready/dest/value)
//   WB_*         : register file write port
//   q_src*/q_hit*: decode-stage pending-write query
//   err_dest     : pulse when a write to the PC register was dropped
// Modports: master = producers/decode/register file side, slave = arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = wb_arb_pkg::DEF_DATA_W,
  parameter int ADDR_W = wb_arb_pkg::DEF_ADDR_W
);

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_dest;
  logic [DATA_W-1:0] a_value;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_dest;
  logic [DATA_W-1:0] b_value;

  logic              WB_EN;
  logic [ADDR_W-1:0] WB_Dest;
  logic [DATA_W-1:0] WB_Value;

  logic [ADDR_W-1:0] q_src1;
  logic [ADDR_W-1:0] q_src2;
  logic              q_hit1;
  logic              q_hit2;

  logic              err_dest;

  modport master (
    output a_valid, a_dest, a_value,
    output b_valid, b_dest, b_value,
    output q_src1, q_src2,
    input  a_ready, b_ready,
    input  WB_EN, WB_Dest, WB_Value,
    input  q_hit1, q_hit2, err_dest
  );

  modport slave (
    input  a_valid, a_dest, a_value,
    input  b_valid, b_dest, b_value,
    input  q_src1, q_src2,
    output a_ready, b_ready,
    output WB_EN, WB_Dest, WB_Value,
    output q_hit1, q_hit2, err_dest
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Small circular FIFO holding pending writebacks for one producer.
// Ports:
//   clk, rst              : clock, synchronous active-high reset (pointers only)
//   push, push_dest/value : enqueue; caller guarantees !full
//   pop                   : dequeue head; caller guarantees !empty
//   head_dest/value       : oldest entry
//   full, empty           : occupancy flags from the registered count
//   ent_vld, ent_dest     : per-slot occupancy and destination, for the query
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_dest,
  input  logic [DATA_W-1:0]        push_value,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_dest,
  output logic [DATA_W-1:0]        head_value,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         ent_vld,
  output logic [DEPTH*ADDR_W-1:0]  ent_dest
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] dest_mem  [DEPTH];
  logic [DATA_W-1:0] value_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [PW-1:0]     off;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr]  <= push_dest;
      value_mem[wr_ptr] <= push_value;
    end
  end

  assign head_dest  = dest_mem[rd_ptr];
  assign head_value = value_mem[rd_ptr];
  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);

  // A slot is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy count; DEPTH is a power of two so the
  // subtraction wraps naturally.
  always_comb begin
    off      = '0;
    ent_vld  = '0;
    ent_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off                         = PW'(i) - rd_ptr;
      ent_vld[i]                  = ({1'b0, off} < count);
      ent_dest[i*ADDR_W +: ADDR_W] = dest_mem[i];
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates two writeback producers onto the register file's single
// write port. Source B (loads) has fixed priority; source A (ALU) is
// forced through after STARVE_LIMIT consecutive B grants while waiting.
// Writes to the PC register are dropped at enqueue and flagged.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_port_arbiter_if.slave (producer channels, WB port,
//              pending-write query, err_dest)
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(REG_PC);

  logic                    a_full, a_empty, b_full, b_empty;
  logic [ADDR_W-1:0]       a_head_dest, b_head_dest;
  logic [DATA_W-1:0]       a_head_value, b_head_value;
  logic [DEPTH-1:0]        a_ent_vld, b_ent_vld;
  logic [DEPTH*ADDR_W-1:0] a_ent_dest, b_ent_dest;

  logic a_hs, b_hs, a_push, b_push;
  logic grant_a, grant_b;
  logic drop_pc;
  logic [SW-1:0] starve_cnt;

  logic              wb_en_p1;
  logic [ADDR_W-1:0] wb_dest_p1;
  logic [DATA_W-1:0] wb_value_p1;
  logic              err_p1;

  logic hit1, hit2;

  assign bus.a_ready = !a_full && !rst;
  assign bus.b_ready = !b_full && !rst;

  assign a_hs    = bus.a_valid && bus.a_ready;
  assign b_hs    = bus.b_valid && bus.b_ready;
  assign a_push  = a_hs && (bus.a_dest != PC_IDX);
  assign b_push  = b_hs && (bus.b_dest != PC_IDX);
  assign drop_pc = (a_hs && (bus.a_dest == PC_IDX)) ||
                   (b_hs && (bus.b_dest == PC_IDX));

  // B wins unless A is waiting and has already been passed over
  // STARVE_LIMIT times in a row.
  assign grant_b = !b_empty && (a_empty || (starve_cnt < SW'(STARVE_LIMIT)));
  assign grant_a = !grant_b && !a_empty;

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst        (rst),
    .push       (a_push),
    .push_dest  (bus.a_dest),
    .push_value (bus.a_value),
    .pop        (grant_a),
    .head_dest  (a_head_dest),
    .head_value (a_head_value),
    .full       (a_full),
    .empty      (a_empty),
    .ent_vld    (a_ent_vld),
    .ent_dest   (a_ent_dest)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst        (rst),
    .push       (b_push),
    .push_dest  (bus.b_dest),
    .push_value (bus.b_value),
    .pop        (grant_b),
    .head_dest  (b_head_dest),
    .head_value (b_head_value),
    .full       (b_full),
    .empty      (b_empty),
    .ent_vld    (b_ent_vld),
    .ent_dest   (b_ent_dest)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_a || a_empty) begin
      starve_cnt <= '0;
    end else if (grant_b && (starve_cnt < SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Output stage p1: registered write port, held steady for a full cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_p1    <= 1'b0;
      wb_dest_p1  <= '0;
      wb_value_p1 <= '0;
      err_p1      <= 1'b0;
    end else begin
      wb_en_p1 <= grant_a || grant_b;
      err_p1   <= drop_pc;
      if (grant_b) begin
        wb_dest_p1  <= b_head_dest;
        wb_value_p1 <= b_head_value;
      end else if (grant_a) begin
        wb_dest_p1  <= a_head_dest;
        wb_value_p1 <= a_head_value;
      end
    end
  end

  assign bus.WB_EN    = wb_en_p1;
  assign bus.WB_Dest  = wb_dest_p1;
  assign bus.WB_Value = wb_value_p1;
  assign bus.err_dest = err_p1;

  // Pending-write query over both FIFOs and the live output stage.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_ent_vld[i] && (a_ent_dest[i*ADDR_W +: ADDR_W] == bus.q_src1)) hit1 = 1'b1;
      if (b_ent_vld[i] && (b_ent_dest[i*ADDR_W +: ADDR_W] == bus.q_src1)) hit1 = 1'b1;
      if (a_ent_vld[i] && (a_ent_dest[i*ADDR_W +: ADDR_W] == bus.q_src2)) hit2 = 1'b1;
      if (b_ent_vld[i] && (b_ent_dest[i*ADDR_W +: ADDR_W] == bus.q_src2)) hit2 = 1'b1;
    end
    if (wb_en_p1 && (wb_dest_p1 == bus.q_src1)) hit1 = 1'b1;
    if (wb_en_p1 && (wb_dest_p1 == bus.q_src2)) hit2 = 1'b1;
    if (bus.q_src1 == PC_IDX) hit1 = 1'b0;
    if (bus.q_src2 == PC_IDX) hit2 = 1'b0;
  end

  assign bus.q_hit1 = hit1;
  assign bus.q_hit2 = hit2;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: two queues of pending writes, a pass-over count and
  // the expected contents of the write port.
  wb_entry_t   qa[$];
  wb_entry_t   qb[$];
  int          sc;
  logic        e_en, e_err;
  logic [3:0]  e_dest;
  logic [31:0] e_val;
  logic [3:0]  qs1, qs2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_hit(input logic [3:0] src);
    if (src == 4'd15) return 1'b0;
    if (e_en && e_dest == src) return 1'b1;
    foreach (qa[i]) if (qa[i].dest == src) return 1'b1;
    foreach (qb[i]) if (qb[i].dest == src) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check pre-edge combinational outputs, advance the model on
  // the edge, then check the registered outputs just after it.
  task automatic step();
    logic r, a_acc, b_acc;
    wb_entry_t ea, eb, e;
    bus.q_src1 = qs1;
    bus.q_src2 = qs2;
    #1;
    check("a_ready", bus.a_ready, !rst && qa.size() < DEPTH);
    check("b_ready", bus.b_ready, !rst && qb.size() < DEPTH);
    check("q_hit1", bus.q_hit1, model_hit(qs1));
    check("q_hit2", bus.q_hit2, model_hit(qs2));
    r     = rst;
    a_acc = !r && bus.a_valid && qa.size() < DEPTH;
    b_acc = !r && bus.b_valid && qb.size() < DEPTH;
    ea.dest = bus.a_dest; ea.value = bus.a_value;
    eb.dest = bus.b_dest; eb.value = bus.b_value;
    @(posedge clk);
    if (r) begin
      qa.delete(); qb.delete();
      sc = 0; e_en = 0; e_dest = 0; e_val = 0; e_err = 0;
    end else begin
      if (qb.size() != 0 && (qa.size() == 0 || sc < LIMIT)) begin
        sc = (qa.size() != 0) ? ((sc < LIMIT) ? sc + 1 : LIMIT) : 0;
        e = qb.pop_front();
        e_en = 1; e_dest = e.dest; e_val = e.value;
      end else if (qa.size() != 0) begin
        sc = 0;
        e = qa.pop_front();
        e_en = 1; e_dest = e.dest; e_val = e.value;
      end else begin
        sc = 0; e_en = 0;
      end
      e_err = (a_acc && ea.dest == 4'd15) || (b_acc && eb.dest == 4'd15);
      if (a_acc && ea.dest != 4'd15) qa.push_back(ea);
      if (b_acc && eb.dest != 4'd15) qb.push_back(eb);
    end
    #1;
    check("WB_EN", bus.WB_EN, e_en);
    check("WB_Dest", bus.WB_Dest, e_dest);
    check("WB_Value", bus.WB_Value, e_val);
    check("err_dest", bus.err_dest, e_err);
  endtask

  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_dest = 0; bus.a_value = 0;
    bus.b_valid = 0; bus.b_dest = 0; bus.b_value = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; qs1 = 0; qs2 = 0;
    idle_inputs();
    sc = 0; e_en = 0; e_dest = 0; e_val = 0; e_err = 0;
    @(posedge clk); #1;

    // Reset held with both producers requesting
    bus.a_valid = 1; bus.a_dest = 3; bus.a_value = 32'h1;
    bus.b_valid = 1; bus.b_dest = 4; bus.b_value = 32'h2;
    qs1 = 3; qs2 = 4;
    step(); step();
    check("rst_a_ready", bus.a_ready, 0);
    check("rst_b_ready", bus.b_ready, 0);
    rst = 0;
    idle_inputs();
    step();
    check("post_rst_en", bus.WB_EN, 0);
    step();
    check("post_rst_en2", bus.WB_EN, 0);

    // Single write from A
    bus.a_valid = 1; bus.a_dest = 3; bus.a_value = 32'hDEADBEEF;
    step();
    idle_inputs();
    step();
    check("single_en", bus.WB_EN, 1);
    check("single_dest", bus.WB_Dest, 3);
    check("single_value", bus.WB_Value, 32'hDEADBEEF);
    step();
    check("single_once", bus.WB_EN, 0);

    // Simultaneous: B first, then A
    bus.a_valid = 1; bus.a_dest = 1; bus.a_value = 32'h11;
    bus.b_valid = 1; bus.b_dest = 2; bus.b_value = 32'h22;
    step();
    idle_inputs();
    step();
    check("sim_first_dest", bus.WB_Dest, 2);
    check("sim_first_value", bus.WB_Value, 32'h22);
    step();
    check("sim_second_dest", bus.WB_Dest, 1);
    check("sim_second_value", bus.WB_Value, 32'h11);
    step();

    // Starvation relief: A holds dest 5 while B streams
    for (int i = 0; i < 5; i++) begin
      bus.a_valid = (i == 0); bus.a_dest = 5; bus.a_value = 32'hA5;
      bus.b_valid = 1; bus.b_dest = 4'(8 + i); bus.b_value = 32'hB0 + i;
      step();
      if (i == 1) check("starve_b0", bus.WB_Dest, 8);
      if (i == 2) check("starve_b1", bus.WB_Dest, 9);
      if (i == 3) check("starve_b2", bus.WB_Dest, 10);
      if (i == 4) check("starve_a", bus.WB_Dest, 5);
    end
    idle_inputs();
    step();
    check("starve_resume", bus.WB_Dest, 11);
    step();
    check("starve_resume2", bus.WB_Dest, 12);
    step();
    check("starve_drain", bus.WB_EN, 0);

    // PC-register writes are dropped and flagged
    bus.b_valid = 1; bus.b_dest = 15; bus.b_value = 32'hFFFF;
    step();
    check("r15_err", bus.err_dest, 1);
    check("r15_no_wb", bus.WB_EN, 0);
    idle_inputs();
    step();
    check("r15_err_pulse", bus.err_dest, 0);
    check("r15_no_wb2", bus.WB_EN, 0);
    bus.a_valid = 1; bus.a_dest = 15; bus.b_valid = 1; bus.b_dest = 15;
    step();
    check("r15_both_err", bus.err_dest, 1);
    idle_inputs();
    step();

    // Full A FIFO, query, then mid-operation reset
    qs1 = 7; qs2 = 15;
    for (int i = 0; i < 2; i++) begin
      bus.a_valid = 1; bus.a_dest = 7; bus.a_value = 32'h70 + i;
      bus.b_valid = 1; bus.b_dest = 9; bus.b_value = 32'h90 + i;
      step();
    end
    bus.a_valid = 0;
    #1;
    check("full_a_ready", bus.a_ready, 0);
    check("full_query", bus.q_hit1, 1);
    check("r15_query", bus.q_hit2, 0);
    rst = 1;
    step();
    check("midrst_en", bus.WB_EN, 0);
    rst = 0;
    idle_inputs();
    #1;
    check("midrst_query", bus.q_hit1, 0);
    check("midrst_a_ready", bus.a_ready, 1);
    step();
    check("midrst_no_wb", bus.WB_EN, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.a_valid = ($urandom_range(0, 2) != 0);
      bus.a_dest  = 4'($urandom_range(0, 15));
      bus.a_value = $urandom;
      bus.b_valid = ($urandom_range(0, 3) < ((n / 50) % 2 == 0 ? 3 : 1));
      bus.b_dest  = 4'($urandom_range(0, 15));
      bus.b_value = $urandom;
      qs1 = 4'($urandom_range(0, 15));
      qs2 = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port (WB_EN / WB_Dest / WB_Value) between two writeback producers: source A (EXE/ALU results) and source B (MEM load results).
- Buffers each source in a small FIFO and grants one write per cycle, with fixed priority to B and starvation relief for A.
- Drives registered outputs straight into the register file's write port.
- Exposes a combinational pending-write query so decode can stall on an in-flight destination.

Parameters:
- DATA_W, 32, writeback value width
- ADDR_W, 4, register index width
- DEPTH, 2, entries per source FIFO (power of two, >=2)
- STARVE_LIMIT, 3, consecutive B grants while A is waiting before A is forced

Ports:
- clk  in  1  single clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  source A write request
- a_ready  out  1  source A FIFO can accept
- a_dest  in  ADDR_W  source A destination register
- a_value  in  DATA_W  source A data
- b_valid  in  1  source B write request
- b_ready  out  1  source B FIFO can accept
- b_dest  in  ADDR_W  source B destination register
- b_value  in  DATA_W  source B data
- WB_EN  out  1  register file write enable (registered)
- WB_Dest  out  ADDR_W  register file write index (registered)
- WB_Value  out  DATA_W  register file write data (registered)
- q_src1, q_src2  in  ADDR_W  decode-stage source indices to check
- q_hit1, q_hit2  out  1  pending write to q_src1 / q_src2 (combinational)
- err_dest  out  1  one-cycle pulse: a write to R15 was dropped (registered)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - WB_EN=0, WB_Dest=0, WB_Value=0, err_dest=0.
  - Both FIFOs empty; starvation counter = 0.
  - a_ready = b_ready = 0 while rst is high (gated by rst); both are 1 in the first cycle after rst falls.
- Handshake:
  - An entry is accepted on a posedge where valid && ready.
  - ready = !full && !rst, computed from the registered count only.
  - A full FIFO accepts nothing, even if it pops in that same cycle (no pass-through).
  - valid does not depend on ready.
- R15 filter:
  - An accepted entry with dest == 15 is discarded at enqueue and never reaches WB.
  - err_dest pulses 1 on the next cycle.
  - If both sources hit this case in the same cycle, err_dest still pulses once.
- Grant, evaluated each posedge:
  - B head present and (A empty or starve_cnt < STARVE_LIMIT) -> pop B.
  - Otherwise, if A is non-empty -> pop A.
  - Popped entry is registered to WB_Dest/WB_Value with WB_EN=1.
  - No pop -> WB_EN=0; WB_Dest/WB_Value hold their last values.
- Starvation counter:
  - +1 when B is granted while A is non-empty, saturating at STARVE_LIMIT.
  - Cleared when A is granted or when A is empty.
- Latency:
  - Handshake at edge k -> granted at edge k+1 at the earliest -> WB_EN high in the cycle after edge k+1.
  - At most one write per cycle.
  - WB outputs are stable for the full cycle, which covers the register file's negedge write.
- Ordering:
  - FIFO order is preserved within each source.
  - Cross-source order to the same register is the producers' responsibility.
- Query: q_hitN = 1 if any valid entry in either FIFO, or the output stage with WB_EN=1, has dest == q_srcN. R15 never hits.
- Reset mid-operation: all buffered entries are dropped; no WB_EN in the cycle after rst is sampled high.

Decomposition:
- Package wb_arb_pkg:
  - DATA_W and ADDR_W defaults.
  - Constant REG_PC = 4'd15.
  - Typedef wb_entry_t {dest, value}.
- Sub-module wb_fifo (parameterised by DEPTH):
  - Ports: push, pop, head, full, empty, plus a flat per-entry valid/dest vector for the query logic.
  - Instantiated twice, once per source.

Test Plan:
- Reset: hold rst for 2 cycles with a_valid=1 and b_valid=1 -> a_ready=b_ready=0, WB_EN=0, WB_Dest=0, WB_Value=0. No entries appear after release.
- Single write: A sends dest 3, 0xDEADBEEF at edge k -> WB_EN=1, WB_Dest=3, WB_Value=0xDEADBEEF during exactly one cycle, after edge k+1.
- Simultaneous: A sends (1, 0x11) and B sends (2, 0x22) in the same cycle -> WB shows dest 2/0x22 first, then dest 1/0x11 on the next cycle.
- Starvation: B streams back-to-back while A holds one entry (dest 5) -> three B writes, then A's dest 5, then B resumes. starve_cnt returns to 0.
- Dest 15: B sends (15, 0xFFFF) -> handshake completes, err_dest pulses 1 for one cycle, and WB_EN stays 0 for it.
- Full / query / reset: with B streaming, push 2 A entries (dest 7) -> a_ready=0 and q_src1=7 gives q_hit1=1. Assert rst for one cycle -> FIFOs cleared, q_hit1=0, WB_EN=0.
